// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multi-cycle MIPS sequencer.
//   state_t  - sequencer steps (3-bit)
//   iclass_t - decoded instruction class consumed by the FSM
//   opcode/funct constants and datapath select codes (NPCOp/ALUOp/ALU_Bop/A3op/REGop)
package mc_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXE, MEM, WB, HALT} state_t;

  typedef enum logic [3:0] {
    C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_ILLEGAL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [2:0] NPC_PC4 = 3'd0;
  localparam logic [2:0] NPC_BEQ = 3'd1;
  localparam logic [2:0] NPC_J   = 3'd2;
  localparam logic [2:0] NPC_JR  = 3'd3;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [3:0] ALU_LUI = 4'd3;

  localparam logic [1:0] BOP_RT  = 2'd0;
  localparam logic [1:0] BOP_IMM = 2'd1;

  localparam logic [1:0] A3_RT = 2'd0;
  localparam logic [1:0] A3_RD = 2'd1;
  localparam logic [1:0] A3_RA = 2'd2;

  localparam logic [1:0] REG_ALU = 2'd0;
  localparam logic [1:0] REG_MEM = 2'd1;
  localparam logic [1:0] REG_PC  = 2'd2;

  // {ALUOp, ALU_Bop, ZeroEXT} for the execute/memory steps of a class
  function automatic logic [6:0] alu_ctl(input iclass_t c);
    logic [6:0] r;
    r = {ALU_ADD, BOP_RT, 1'b0};
    case (c)
      C_SUBU, C_BEQ: r = {ALU_SUB, BOP_RT, 1'b0};
      C_ORI:         r = {ALU_OR, BOP_IMM, 1'b1};
      C_LUI:         r = {ALU_LUI, BOP_IMM, 1'b0};
      C_LW, C_SW:    r = {ALU_ADD, BOP_IMM, 1'b0};
      default:       r = {ALU_ADD, BOP_RT, 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode/funct -> instruction class.
//   opcode, funct : IR fields
//   cls           : decoded class, C_ILLEGAL for anything unsupported
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    cls
);

  always_comb begin
    cls = C_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls = C_ADDU;
          FN_SUBU: cls = C_SUBU;
          FN_JR:   cls = C_JR;
          default: cls = C_ILLEGAL;
        endcase
      end
      OP_ORI:  cls = C_ORI;
      OP_LUI:  cls = C_LUI;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      default: cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle FETCH/DECODE/EXE/MEM/WB sequencer for the MIPS datapath.
//   clk, reset (async, active low)
//   opcode/funct/zero        : from datapath
//   mem_ready / mem_req      : unified memory handshake, MemWrite for stores
//   pc_write/ir_write/RegWrite and NPCOp/ALUOp/ALU_Bop/ZeroEXT/A3op/REGop : datapath controls
//   instr_done/illegal       : per-instruction pulses, halted: memory timeout level
module mc_controller
  import mc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       pc_write,
  output logic       ir_write,
  output logic       RegWrite,
  output logic [2:0] NPCOp,
  output logic [3:0] ALUOp,
  output logic [1:0] ALU_Bop,
  output logic       ZeroEXT,
  output logic [1:0] A3op,
  output logic [1:0] REGop,
  output logic       instr_done,
  output logic       illegal,
  output logic       halted
);

  state_t           state, nxt;
  iclass_t          cls;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_phase, expire;

  // all controls packed so the reset gate is a single AND
  logic [21:0] ctl;

  mc_decode u_dec (.opcode(opcode), .funct(funct), .cls(cls));

  assign mem_phase = (state == FETCH) || (state == MEM);
  // a completing access in the last allowed cycle beats the timeout
  assign expire    = (TIMEOUT_CYC != 0) && mem_phase && !mem_ready &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYC));

  always_comb begin
    logic       c_req, c_mw, c_pcw, c_irw, c_rw, c_done, c_ill, c_halt;
    logic [2:0] c_npc;
    logic [6:0] c_alu;
    logic [1:0] c_a3, c_reg;
    c_req = 1'b0; c_mw = 1'b0; c_pcw = 1'b0; c_irw = 1'b0; c_rw = 1'b0;
    c_done = 1'b0; c_ill = 1'b0; c_halt = 1'b0;
    c_npc = NPC_PC4; c_alu = '0; c_a3 = A3_RT; c_reg = REG_ALU;
    nxt = state;
    case (state)
      FETCH: begin
        c_req = 1'b1;
        if (mem_ready) begin
          c_irw = 1'b1;
          c_pcw = 1'b1;
          nxt   = DECODE;
        end else if (expire) nxt = HALT;
      end
      DECODE: begin
        nxt = EXE;
        case (cls)
          C_J:   begin c_pcw = 1'b1; c_npc = NPC_J; c_done = 1'b1; nxt = FETCH; end
          C_JAL: begin
            c_pcw = 1'b1; c_npc = NPC_J; c_rw = 1'b1; c_a3 = A3_RA; c_reg = REG_PC;
            c_done = 1'b1; nxt = FETCH;
          end
          C_JR:  begin c_pcw = 1'b1; c_npc = NPC_JR; c_done = 1'b1; nxt = FETCH; end
          // PC was already advanced in FETCH, so an illegal op just retires
          C_ILLEGAL: begin c_ill = 1'b1; c_done = 1'b1; nxt = FETCH; end
          default: nxt = EXE;
        endcase
      end
      EXE: begin
        c_alu = alu_ctl(cls);
        if (cls == C_BEQ) begin
          c_pcw = zero; c_npc = NPC_BEQ; c_done = 1'b1; nxt = FETCH;
        end else if (cls == C_LW || cls == C_SW) nxt = MEM;
        else nxt = WB;
      end
      MEM: begin
        c_req = 1'b1;
        c_mw  = (cls == C_SW);
        c_alu = alu_ctl(cls);   // address must stay valid while memory stalls
        if (mem_ready) begin
          if (cls == C_SW) begin c_done = 1'b1; nxt = FETCH; end
          else nxt = WB;
        end else if (expire) nxt = HALT;
      end
      WB: begin
        c_rw = 1'b1; c_done = 1'b1; nxt = FETCH;
        if (cls == C_ADDU || cls == C_SUBU) c_a3 = A3_RD;
        if (cls == C_LW) c_reg = REG_MEM;
      end
      HALT: c_halt = 1'b1;
      default: nxt = FETCH;
    endcase
    ctl = {c_req, c_mw, c_pcw, c_irw, c_rw, c_npc, c_alu, c_a3, c_reg, c_done, c_ill, c_halt};
  end

  // nothing may leak to the datapath while reset is held, even combinationally
  assign {mem_req, MemWrite, pc_write, ir_write, RegWrite, NPCOp, ALUOp, ALU_Bop, ZeroEXT,
          A3op, REGop, instr_done, illegal, halted} = reset ? ctl : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= nxt;
      wait_cnt <= (mem_phase && !mem_ready && !expire) ? wait_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  logic       clk = 1'b0, reset = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       mem_req, MemWrite, pc_write, ir_write, RegWrite, ZeroEXT;
  logic       instr_done, illegal, halted;
  logic [2:0] NPCOp;
  logic [3:0] ALUOp;
  logic [1:0] ALU_Bop, A3op, REGop;

  mc_controller #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite), .pc_write(pc_write),
    .ir_write(ir_write), .RegWrite(RegWrite), .NPCOp(NPCOp), .ALUOp(ALUOp),
    .ALU_Bop(ALU_Bop), .ZeroEXT(ZeroEXT), .A3op(A3op), .REGop(REGop),
    .instr_done(instr_done), .illegal(illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  typedef struct {
    string      nm;
    logic [5:0] op, fn;
    logic       z;
    int         cpi;
    logic [11:0] dv;   // {pc_write,NPCOp,RegWrite,A3op,REGop,illegal,MemWrite,mem_req} at done step
    logic [6:0]  av;   // {ALUOp,ALU_Bop,ZeroEXT} in EXE/MEM
  } vec_t;

  typedef struct { string nm; int cpi; logic [11:0] dv; } exp_t;
  exp_t sbq[$];
  vec_t vt[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [21:0] allv();
    return {mem_req, MemWrite, pc_write, ir_write, RegWrite, NPCOp, ALUOp, ALU_Bop, ZeroEXT,
            A3op, REGop, instr_done, illegal, halted};
  endfunction

  function automatic logic [11:0] mkd(input logic pc, input logic [2:0] npc, input logic rw,
                                      input logic [1:0] a3, input logic [1:0] rg,
                                      input logic ill, input logic mw, input logic mr);
    return {pc, npc, rw, a3, rg, ill, mw, mr};
  endfunction

  function automatic vec_t mkv(input string nm, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input int cpi, input logic [11:0] dv,
                               input logic [6:0] av);
    vec_t v;
    v.nm = nm; v.op = op; v.fn = fn; v.z = z; v.cpi = cpi; v.dv = dv; v.av = av;
    return v;
  endfunction

  // Runs one instruction starting at a negedge in FETCH; ends at the negedge after retire.
  // mwait: cycles mem_ready stays low during the data access.
  task automatic run_instr(input vec_t v, input int mwait, output int alu_bad);
    int cyc = 0, acc = 0, waited = 0;
    bit done = 0;
    exp_t e;
    logic [11:0] dvs = '0;
    alu_bad = 0;
    sbq.push_back('{v.nm, v.cpi, v.dv});
    opcode = v.op; funct = v.fn; zero = v.z;
    while (!done && cyc < 30) begin
      cyc++;
      #1;
      if (mem_req) begin
        if (acc == 1 && waited < mwait) begin mem_ready = 1'b0; waited++; end
        else mem_ready = 1'b1;
      end else mem_ready = 1'b0;
      #1;
      if (cyc == 1) chk({v.nm, "_fetch"}, {mem_req, ir_write, pc_write, NPCOp}, 6'b111000);
      if (cyc == 3 && v.cpi >= 3) chk({v.nm, "_exe_alu"}, {ALUOp, ALU_Bop, ZeroEXT}, v.av);
      if (cyc >= 3 && mem_req && {ALUOp, ALU_Bop, ZeroEXT} !== v.av) alu_bad++;
      if (mem_req && mem_ready) acc++;
      if (instr_done) begin
        done = 1;
        dvs = {pc_write, NPCOp, RegWrite, A3op, REGop, illegal, MemWrite, mem_req};
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    if (!done) begin
      chk({v.nm, "_retire_timeout"}, 0, 1);
      void'(sbq.pop_front());
    end else begin
      e = sbq.pop_front();
      chk({e.nm, "_cpi"}, cyc, e.cpi);
      chk({e.nm, "_done_ctl"}, dvs, e.dv);
    end
  endtask

  initial begin
    int ab;
    vec_t lw8;
    vt[0]  = mkv("addu", 6'h00, 6'h21, 0, 4, mkd(0,0,1,1,0,0,0,0), {4'd0,2'd0,1'b0});
    vt[1]  = mkv("subu", 6'h00, 6'h23, 0, 4, mkd(0,0,1,1,0,0,0,0), {4'd1,2'd0,1'b0});
    vt[2]  = mkv("ori",  6'h0D, 6'h08, 0, 4, mkd(0,0,1,0,0,0,0,0), {4'd2,2'd1,1'b1});
    vt[3]  = mkv("lui",  6'h0F, 6'h21, 0, 4, mkd(0,0,1,0,0,0,0,0), {4'd3,2'd1,1'b0});
    vt[4]  = mkv("lw",   6'h23, 6'h00, 0, 5, mkd(0,0,1,0,1,0,0,0), {4'd0,2'd1,1'b0});
    vt[5]  = mkv("sw",   6'h2B, 6'h00, 0, 4, mkd(0,0,0,0,0,0,1,1), {4'd0,2'd1,1'b0});
    vt[6]  = mkv("beq_t",6'h04, 6'h00, 1, 3, mkd(1,1,0,0,0,0,0,0), {4'd1,2'd0,1'b0});
    vt[7]  = mkv("beq_n",6'h04, 6'h00, 0, 3, mkd(0,1,0,0,0,0,0,0), {4'd1,2'd0,1'b0});
    vt[8]  = mkv("j",    6'h02, 6'h00, 0, 2, mkd(1,2,0,0,0,0,0,0), '0);
    vt[9]  = mkv("jal",  6'h03, 6'h00, 0, 2, mkd(1,2,1,2,2,0,0,0), '0);
    vt[10] = mkv("jr",   6'h00, 6'h08, 0, 2, mkd(1,3,0,0,0,0,0,0), '0);
    vt[11] = mkv("ill3f",6'h3F, 6'h00, 0, 2, mkd(0,0,0,0,0,1,0,0), '0);
    vt[12] = mkv("ill_add",6'h00,6'h20,0, 2, mkd(0,0,0,0,0,1,0,0), '0);

    // reset held: no strobe may leak, whatever the inputs say
    opcode = 6'h2B; mem_ready = 1'b1; zero = 1'b1;
    #2 chk("reset_outputs", allv(), 0);
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0;
    #1 chk("release_fetch", {mem_req, MemWrite, ir_write, halted}, 4'b1000);
    @(negedge clk);

    foreach (vt[i]) run_instr(vt[i], 0, ab);

    // lw with three stalled data cycles
    lw8 = vt[4]; lw8.nm = "lw_wait3"; lw8.cpi = 8;
    run_instr(lw8, 3, ab);
    chk("lw_wait3_alu_stable", ab, 0);

    // reset mid-MEM of sw
    opcode = 6'h2B; funct = '0; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("sw_in_mem", {mem_req, MemWrite}, 2'b11);
    #1 reset = 1'b0;
    #1 chk("reset_mid_mem", allv(), 0);
    @(negedge clk); reset = 1'b1;
    #1 chk("sw_reset_release", {mem_req, MemWrite, ir_write, instr_done}, 4'b1000);
    @(negedge clk);
    run_instr(vt[0], 0, ab);

    // fetch timeout: ready never comes
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk); reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      if (k == 5) chk("to_fetch5", {mem_req, halted}, 2'b10);
      @(negedge clk);
    end
    #1 chk("to_halted", allv(), 22'h1);
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 chk("to_halt_sticky", {halted, mem_req, ir_write}, 3'b100);
    @(negedge clk);

    // ready on the last permitted cycle wins over the timeout
    reset = 1'b0; mem_ready = 1'b0; opcode = 6'h02;
    @(negedge clk); reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      mem_ready = (k == 5);
      #1;
      if (k == 5) chk("to_ready5", {ir_write, halted}, 2'b10);
      @(negedge clk);
    end
    mem_ready = 1'b0;
    #1 chk("to_ready_decode", {halted, instr_done, pc_write, NPCOp}, 6'b011010);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
